// File: rtl/ahbl_stream_port_pkg.sv
// Shared constants and types for the AHB-Lite stream port: register map, bit positions,
// read default and stall timeout limit.
package ahbl_stream_port_pkg;

    localparam logic [7:0] OFF_DATA   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_CTRL   = 8'h08;
    localparam logic [7:0] OFF_FLUSH  = 8'h0C;

    localparam int unsigned ST_TX_FULL    = 0;
    localparam int unsigned ST_TX_EMPTY   = 1;
    localparam int unsigned ST_RX_FULL    = 2;
    localparam int unsigned ST_RX_EMPTY   = 3;
    localparam int unsigned ST_OVF        = 4;
    localparam int unsigned ST_UNF        = 5;
    localparam int unsigned ST_TMO        = 6;
    localparam int unsigned ST_TX_LVL_LSB = 8;
    localparam int unsigned ST_RX_LVL_LSB = 16;

    localparam int unsigned CT_EN      = 0;
    localparam int unsigned CT_STALL   = 1;
    localparam int unsigned CT_THR_LSB = 8;

    localparam int unsigned FL_TX = 0;
    localparam int unsigned FL_RX = 1;

    localparam logic [31:0] READ_DEFAULT  = 32'hDEAD_BEEF;
    localparam logic [7:0]  TIMEOUT_LIMIT = 8'd255;

    // Captured address-phase fields, live for the whole data phase.
    typedef struct packed {
        logic       valid;
        logic       write;
        logic [7:0] addr;
    } dphase_t;

endpackage

// File: rtl/ahbl_stream_port_if.sv
// AHB-Lite slave signals plus the TX/RX valid/ready streams of the stream port.
interface ahbl_stream_port_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        IRQ;
    logic [31:0] tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready;
    logic [31:0] rx_tdata;
    logic        rx_tvalid;
    logic        rx_tready;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, tx_tready, rx_tdata, rx_tvalid,
        input  HRDATA, HREADYOUT, IRQ, tx_tdata, tx_tvalid, rx_tready
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, tx_tready, rx_tdata, rx_tvalid,
        output HRDATA, HREADYOUT, IRQ, tx_tdata, tx_tvalid, rx_tready
    );
endinterface

// File: rtl/ahbl_sync_fifo.sv
// Synchronous FIFO with registered level, push/pop/flush and head-of-queue output.
// Flush has priority over a same-cycle push or pop.
module ahbl_sync_fifo #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned WIDTH      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i & ~full_o & ~flush_i;
        do_pop   = pop_i & ~empty_o & ~flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            if (do_push && !do_pop)      level_d = level_q + LW'(1);
            else if (do_pop && !do_push) level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; the level qualifies every entry.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ahbl_stream_port.sv
// AHB-Lite responder bridging DATA accesses to TX/RX valid/ready streams via two FIFOs.
// Optional build macro AHBL_STREAM_PORT_TIMEOUT_EN bounds stalls at 255 wait states.
module ahbl_stream_port
    import ahbl_stream_port_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahbl_stream_port_if.slave bus
);
    localparam int unsigned LW = DEPTH_LOG2 + 1;

    dphase_t       dph_q, dph_d;
    logic          en_q, en_d, stall_q, stall_d;
    logic [7:0]    thr_q, thr_d;
    logic          ovf_q, ovf_d, unf_q, unf_d, tmo_q, tmo_d;

    logic [31:0]   tx_head, rx_head;
    logic [LW-1:0] tx_level, rx_level;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, rx_push, rx_pop, tx_flush, rx_flush;
    logic          wr_data, rd_data, reg_wr, stall_raw, timed_out, stall_c;
    logic          ovf_set, unf_set;
    logic [31:0]   status_c, ctrl_c, hrdata_c;
    logic          unused_c;

    assign unused_c = ^{bus.HSIZE, bus.HADDR[31:8], bus.HTRANS[0]};

    ahbl_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(32)) u_tx_fifo (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .push_i  (tx_push),
        .data_i  (bus.HWDATA),
        .pop_i   (tx_pop),
        .flush_i (tx_flush),
        .data_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (tx_level)
    );

    ahbl_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(32)) u_rx_fifo (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .push_i  (rx_push),
        .data_i  (bus.rx_tdata),
        .pop_i   (rx_pop),
        .flush_i (rx_flush),
        .data_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level)
    );

    // Data-phase decode; full/empty tests see only the registered levels.
    always_comb begin
        wr_data   = dph_q.valid & dph_q.write & (dph_q.addr == OFF_DATA);
        rd_data   = dph_q.valid & ~dph_q.write & (dph_q.addr == OFF_DATA);
        reg_wr    = dph_q.valid & dph_q.write;
        stall_raw = stall_q & ((wr_data & tx_full) | (rd_data & rx_empty));
        ovf_set   = wr_data & tx_full & ~stall_q;
        unf_set   = rd_data & rx_empty & ~stall_q;
        tx_push   = wr_data & ~tx_full;
        rx_pop    = rd_data & ~rx_empty;
        tx_pop    = ~tx_empty & en_q & bus.tx_tready;
        rx_push   = ~rx_full & en_q & bus.rx_tvalid;
    end

`ifdef AHBL_STREAM_PORT_TIMEOUT_EN
    logic [7:0] stall_cnt_q, stall_cnt_d;

    assign timed_out   = stall_raw & (stall_cnt_q == TIMEOUT_LIMIT);
    assign stall_cnt_d = stall_c ? stall_cnt_q + 8'd1 : 8'd0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end
`else
    assign timed_out = 1'b0;
`endif

    assign stall_c = stall_raw & ~timed_out;

    always_comb begin
        status_c                         = '0;
        status_c[ST_TX_FULL]             = tx_full;
        status_c[ST_TX_EMPTY]            = tx_empty;
        status_c[ST_RX_FULL]             = rx_full;
        status_c[ST_RX_EMPTY]            = rx_empty;
        status_c[ST_OVF]                 = ovf_q;
        status_c[ST_UNF]                 = unf_q;
        status_c[ST_TMO]                 = tmo_q;
        status_c[ST_TX_LVL_LSB +: 8]     = 8'(tx_level);
        status_c[ST_RX_LVL_LSB +: 8]     = 8'(rx_level);
        ctrl_c                           = '0;
        ctrl_c[CT_EN]                    = en_q;
        ctrl_c[CT_STALL]                 = stall_q;
        ctrl_c[CT_THR_LSB +: 8]          = thr_q;
    end

    always_comb begin
        hrdata_c = '0;
        if (dph_q.valid && !dph_q.write) begin
            case (dph_q.addr)
                OFF_DATA:   hrdata_c = rx_empty ? READ_DEFAULT : rx_head;
                OFF_STATUS: hrdata_c = status_c;
                OFF_CTRL:   hrdata_c = ctrl_c;
                OFF_FLUSH:  hrdata_c = '0;
                default:    hrdata_c = READ_DEFAULT;
            endcase
        end
    end

    // Next-state for the data-phase capture, control and sticky flags; a flag set wins over its clear.
    always_comb begin
        dph_d    = dph_q;
        en_d     = en_q;
        stall_d  = stall_q;
        thr_d    = thr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        tmo_d    = tmo_q;
        tx_flush = 1'b0;
        rx_flush = 1'b0;

        if (!stall_c) begin
            dph_d = '0;
            if (bus.HREADY) begin
                dph_d.valid = bus.HSEL & bus.HTRANS[1];
                dph_d.write = bus.HWRITE;
                dph_d.addr  = bus.HADDR[7:0];
            end
        end

        if (reg_wr && dph_q.addr == OFF_STATUS) begin
            if (bus.HWDATA[ST_OVF]) ovf_d = 1'b0;
            if (bus.HWDATA[ST_UNF]) unf_d = 1'b0;
            if (bus.HWDATA[ST_TMO]) tmo_d = 1'b0;
        end
        if (reg_wr && dph_q.addr == OFF_CTRL) begin
            en_d    = bus.HWDATA[CT_EN];
            stall_d = bus.HWDATA[CT_STALL];
            thr_d   = bus.HWDATA[CT_THR_LSB +: 8];
        end
        if (reg_wr && dph_q.addr == OFF_FLUSH) begin
            tx_flush = bus.HWDATA[FL_TX];
            rx_flush = bus.HWDATA[FL_RX];
        end

        if (ovf_set)   ovf_d = 1'b1;
        if (unf_set)   unf_d = 1'b1;
        if (timed_out) tmo_d = 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dph_q   <= '0;
            en_q    <= 1'b0;
            stall_q <= 1'b0;
            thr_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            dph_q   <= dph_d;
            en_q    <= en_d;
            stall_q <= stall_d;
            thr_q   <= thr_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.HRDATA    = hrdata_c;
    assign bus.HREADYOUT = ~stall_c;
    assign bus.IRQ       = ((thr_q != 8'd0) && (8'(rx_level) >= thr_q)) | ovf_q | unf_q | tmo_q;
    assign bus.tx_tdata  = tx_head;
    assign bus.tx_tvalid = ~tx_empty & en_q;
    assign bus.rx_tready = ~rx_full & en_q;

endmodule

// File: tb/tb_ahbl_stream_port.sv
// Directed bench for ahbl_stream_port: register map, stream ordering, stalls, flags, flush, reset.
// Timeout checks are built when AHBL_STREAM_PORT_TIMEOUT_EN is defined.
module tb_ahbl_stream_port;
    import ahbl_stream_port_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] tx_seen [$];

    ahbl_stream_port_if bus();

    ahbl_stream_port #(.DEPTH_LOG2(3)) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    assign bus.HREADY = bus.HREADYOUT;

    always @(negedge clk) begin
        if (rst_n && bus.tx_tvalid && bus.tx_tready) tx_seen.push_back(bus.tx_tdata);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Single AHB transfer; starts and ends just after a rising edge.
    task automatic ahb_xfer(input logic [7:0] addr, input logic wr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int waits);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = BASE | {24'h0, addr};
        bus.HWRITE = wr;
        @(posedge clk); #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = wdata;
        waits = 0;
        @(negedge clk);
        while (bus.HREADYOUT !== 1'b1 && waits < 400) begin
            waits++;
            @(negedge clk);
        end
        rdata = bus.HRDATA;
        @(posedge clk); #1;
    endtask

    task automatic ahb_wr(input logic [7:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        int w;
        ahb_xfer(addr, 1'b1, wdata, d, w);
    endtask

    task automatic ahb_rd(input logic [7:0] addr, output logic [31:0] rdata);
        int w;
        ahb_xfer(addr, 1'b0, 32'h0, rdata, w);
    endtask

    task automatic rx_push(input logic [31:0] d);
        bus.rx_tdata  = d;
        bus.rx_tvalid = 1'b1;
        @(posedge clk); #1;
        bus.rx_tvalid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int w;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HADDR = '0; bus.HWRITE = 1'b0;
        bus.HSIZE = 3'b010; bus.HWDATA = '0;
        bus.tx_tready = 1'b0; bus.rx_tdata = '0; bus.rx_tvalid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check32("rst_hrdata",    bus.HRDATA,         32'd0);
        check32("rst_irq",       32'(bus.IRQ),       32'd0);
        check32("rst_tx_tvalid", 32'(bus.tx_tvalid), 32'd0);
        check32("rst_rx_tready", 32'(bus.rx_tready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        ahb_rd(OFF_STATUS, rd); check32("rst_status", rd, 32'h0000_000A);
        ahb_rd(OFF_CTRL, rd);   check32("rst_ctrl",   rd, 32'h0);
        ahb_rd(8'h10, rd);      check32("unmapped_rd", rd, 32'hDEAD_BEEF);
        ahb_rd(OFF_FLUSH, rd);  check32("flush_rd",   rd, 32'h0);

        // Streaming writes drain in order
        ahb_wr(OFF_CTRL, 32'h1);
        bus.tx_tready = 1'b1;
        tx_seen.delete();
        for (int k = 1; k <= 8; k++) ahb_wr(OFF_DATA, 32'h1111_1111 * k);
        ahb_rd(OFF_STATUS, rd); check32("stream_status", rd, 32'h0000_000A);
        check32("stream_count", 32'(tx_seen.size()), 32'd8);
        for (int k = 1; k <= 8; k++)
            check32($sformatf("stream_word%0d", k),
                    (tx_seen.size() >= k) ? tx_seen[k-1] : 32'hx, 32'h1111_1111 * k);

        // Overflow with STALL=0
        bus.tx_tready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ahb_wr(OFF_DATA, 32'h100 + i);
            if (i == 0) begin
                @(negedge clk);
                check32("wr_latency_valid", 32'(bus.tx_tvalid), 32'd1);
                check32("wr_latency_data",  bus.tx_tdata,       32'h100);
                @(posedge clk); #1;
            end
        end
        ahb_rd(OFF_STATUS, rd); check32("ovf_status", rd, 32'h0000_0819);
        @(negedge clk); check32("ovf_irq", 32'(bus.IRQ), 32'd1);
        @(posedge clk); #1;
        ahb_wr(OFF_STATUS, 32'h10);
        ahb_rd(OFF_STATUS, rd); check32("ovf_clear", rd, 32'h0000_0809);
        @(negedge clk); check32("ovf_clear_irq", 32'(bus.IRQ), 32'd0);
        @(posedge clk); #1;

        ahb_wr(OFF_CTRL, 32'h3);
`ifdef AHBL_STREAM_PORT_TIMEOUT_EN
        ahb_xfer(OFF_DATA, 1'b1, 32'h66, rd, w);
        check32("tmo_waits", 32'(w), 32'd255);
        ahb_rd(OFF_STATUS, rd); check32("tmo_status", rd, 32'h0000_0849);
        ahb_wr(OFF_STATUS, 32'h40);
        ahb_rd(OFF_STATUS, rd); check32("tmo_clear", rd, 32'h0000_0809);
`endif

        // Stalled write released by a stream pop
        tx_seen.delete();
        fork
            ahb_xfer(OFF_DATA, 1'b1, 32'h55, rd, w);
            begin
                repeat (3) @(posedge clk);
                #1 bus.tx_tready = 1'b1;
                @(posedge clk); #1 bus.tx_tready = 1'b0;
            end
        join
        check32("stall_wr_waits", 32'(w), 32'd3);
        check32("stall_wr_popped", (tx_seen.size() > 0) ? tx_seen[0] : 32'hx, 32'h100);
        ahb_rd(OFF_STATUS, rd); check32("stall_wr_status", rd, 32'h0000_0809);
        @(negedge clk); check32("stall_wr_head", bus.tx_tdata, 32'h101);
        @(posedge clk); #1;
        ahb_wr(OFF_FLUSH, 32'h1);
        ahb_rd(OFF_STATUS, rd); check32("tx_flush_status", rd, 32'h0000_000A);

        // Stalled read released by a stream push
        fork
            ahb_xfer(OFF_DATA, 1'b0, 32'h0, rd, w);
            begin
                repeat (3) @(posedge clk);
                #1 rx_push(32'hCAFE_F00D);
            end
        join
        check32("stall_rd_waits", 32'(w), 32'd3);
        check32("stall_rd_data",  rd,        32'hCAFE_F00D);
        ahb_rd(OFF_STATUS, rd); check32("stall_rd_status", rd, 32'h0000_000A);

        // RX threshold interrupt
        ahb_wr(OFF_CTRL, 32'h0401);
        ahb_rd(OFF_CTRL, rd); check32("ctrl_rd", rd, 32'h0000_0401);
        for (int i = 1; i <= 3; i++) rx_push(32'h200 + i);
        @(negedge clk); check32("thr_irq_below", 32'(bus.IRQ), 32'd0);
        @(posedge clk); #1;
        rx_push(32'h204);
        @(negedge clk); check32("thr_irq_at", 32'(bus.IRQ), 32'd1);
        @(posedge clk); #1;
        ahb_rd(OFF_STATUS, rd); check32("thr_status", rd, 32'h0004_0002);
        ahb_xfer(OFF_DATA, 1'b0, 32'h0, rd, w);
        check32("rx_pop_data",  rd,        32'h201);
        check32("rx_pop_waits", 32'(w),    32'd0);
        @(negedge clk); check32("thr_irq_after", 32'(bus.IRQ), 32'd0);
        @(posedge clk); #1;

        // Underflow with STALL=0
        for (int i = 2; i <= 4; i++) begin
            ahb_rd(OFF_DATA, rd); check32($sformatf("rx_pop%0d", i), rd, 32'h200 + i);
        end
        ahb_xfer(OFF_DATA, 1'b0, 32'h0, rd, w);
        check32("unf_data",  rd,     32'hDEAD_BEEF);
        check32("unf_waits", 32'(w), 32'd0);
        ahb_rd(OFF_STATUS, rd); check32("unf_status", rd, 32'h0000_002A);
        @(negedge clk); check32("unf_irq", 32'(bus.IRQ), 32'd1);
        @(posedge clk); #1;
        ahb_wr(OFF_STATUS, 32'h20);
        ahb_rd(OFF_STATUS, rd); check32("unf_clear", rd, 32'h0000_000A);

        // Flush both FIFOs while the RX stream keeps pushing
        rx_push(32'h301); rx_push(32'h302);
        ahb_wr(OFF_DATA, 32'h401); ahb_wr(OFF_DATA, 32'h402);
        ahb_rd(OFF_STATUS, rd); check32("pre_flush_status", rd, 32'h0002_0200);
        bus.rx_tdata  = 32'h77;
        bus.rx_tvalid = 1'b1;
        ahb_wr(OFF_FLUSH, 32'h3);
        bus.rx_tvalid = 1'b0;
        ahb_rd(OFF_STATUS, rd); check32("flush_status", rd, 32'h0000_000A);

        // Reset during a stalled read
        ahb_wr(OFF_CTRL, 32'h3);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = BASE | 32'(OFF_DATA); bus.HWRITE = 1'b0;
        @(posedge clk); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        @(negedge clk); check32("mid_stall_hreadyout", 32'(bus.HREADYOUT), 32'd0);
        #2 rst_n = 1'b0;
        #1 check32("async_rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check32("async_rst_rx_tready", 32'(bus.rx_tready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // EN=0 gates only the stream side
        ahb_wr(OFF_DATA, 32'h99);
        rx_push(32'h88);
        ahb_rd(OFF_STATUS, rd); check32("en0_status", rd, 32'h0000_0108);
        @(negedge clk);
        check32("en0_tx_tvalid", 32'(bus.tx_tvalid), 32'd0);
        check32("en0_rx_tready", 32'(bus.rx_tready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
